// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response channel: request fields flow master->slave,
// addr_ok/data_ok/rdata flow back.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

    // Read-only slave view for the instruction port, which has no write fields.
    modport ro_slave (
        input  req, size, addr,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter with an in-order owner
// FIFO for routing responses and in-flight cancellation of instruction beats.
module sram_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    sram_req_arbiter_if.ro_slave      inst_s,
    sram_req_arbiter_if.slave         data_s,
    sram_req_arbiter_if.master        mem_m,
    input  logic                      inst_cancel_i,
    output logic                      busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lock_e;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_INST = 2'd1,
        G_DATA = 2'd2
    } gnt_e;

    lock_e            lock_q, lock_d;
    gnt_e             gnt;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] own_q, own_d;
    logic [DEPTH-1:0] drop_q, drop_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             push_own;
    logic             head_own;
    logic             head_drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q  <= LK_NONE;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            own_q   <= '0;
            drop_q  <= '0;
        end else begin
            lock_q  <= lock_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            own_q   <= own_d;
            drop_q  <= drop_d;
        end
    end

    assign full = (count_q == CW'(DEPTH));

    // A held lock overrides everything; it never forms while full, so a locked
    // request always has room in the FIFO when it is finally accepted.
    always_comb begin
        gnt = G_NONE;
        unique case (lock_q)
            LK_INST: gnt = G_INST;
            LK_DATA: gnt = G_DATA;
            default: begin
                if (!full) begin
                    if (data_s.req) begin
                        gnt = G_DATA;
                    end else if (inst_s.req) begin
                        gnt = G_INST;
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_m.req      = 1'b0;
        mem_m.wr       = 1'b0;
        mem_m.size     = 2'd0;
        mem_m.wstrb    = 4'd0;
        mem_m.addr     = 32'd0;
        mem_m.wdata    = 32'd0;
        unique case (gnt)
            G_DATA: begin
                mem_m.req   = data_s.req;
                mem_m.wr    = data_s.wr;
                mem_m.size  = data_s.size;
                mem_m.wstrb = data_s.wstrb;
                mem_m.addr  = data_s.addr;
                mem_m.wdata = data_s.wdata;
            end
            G_INST: begin
                mem_m.req   = inst_s.req;
                mem_m.size  = inst_s.size;
                mem_m.addr  = inst_s.addr;
            end
            default: ;
        endcase
    end

    assign push           = mem_m.req & mem_m.addr_ok;
    assign push_own       = (gnt == G_DATA);
    assign data_s.addr_ok = push & (gnt == G_DATA);
    assign inst_s.addr_ok = push & (gnt == G_INST);

    always_comb begin
        lock_d = lock_q;
        if (mem_m.req) begin
            if (mem_m.addr_ok) begin
                lock_d = LK_NONE;
            end else begin
                lock_d = (gnt == G_DATA) ? LK_DATA : LK_INST;
            end
        end
    end

    // Beats arriving with nothing outstanding are protocol errors and ignored.
    assign pop       = mem_m.data_ok & (count_q != '0);
    assign head_own  = own_q[rptr_q];
    assign head_drop = drop_q[rptr_q];

    assign data_s.data_ok = pop & head_own;
    assign inst_s.data_ok = pop & ~head_own & ~head_drop & ~inst_cancel_i;
    assign data_s.rdata   = mem_m.rdata;
    assign inst_s.rdata   = mem_m.rdata;

    always_comb begin
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Per-entry update: a push writes the slot; otherwise a cancel marks every
    // live inst entry (including the head being popped this cycle) as dropped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [AW-1:0] off;
        logic          live;
        logic          wr_hit;

        assign off    = AW'(gi) - rptr_q;
        assign live   = ({1'b0, off} < count_q);
        assign wr_hit = push & (wptr_q == AW'(gi));

        assign own_d[gi]  = wr_hit ? push_own : own_q[gi];
        assign drop_d[gi] = wr_hit ? (~push_own & inst_cancel_i)
                                   : (drop_q[gi] | (inst_cancel_i & live & ~own_q[gi]));
    end

    assign busy_o = (count_q != '0);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized self-checking bench: a queue-based model predicts every cycle's
// downstream request and every response beat; a monitor compares at negedge.
module tb_sram_req_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    logic inst_cancel;
    logic busy;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if mem_if ();

    sram_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_s        (inst_if),
        .data_s        (data_if),
        .mem_m         (mem_if),
        .inst_cancel_i (inst_cancel),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        mreq;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iaok;
        logic        daok;
        logic        busy;
    } cyc_t;

    typedef struct {
        logic        iok;
        logic        dok;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        bit own;
        bit drop;
    } ent_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];
    ent_t mdl_q[$];
    bit   stall_v;
    bit   stall_own;
    bit   inst_pend;
    bit   data_pend;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes one per-cycle expectation and, on any response activity,
    // one response expectation.
    always @(negedge clk) begin
        cyc_t e;
        rsp_t r;
        if (mon_en) begin
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                check("mem_req", mem_if.req, e.mreq);
                check("mem_fields",
                      {mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata},
                      {e.wr, e.size, e.wstrb, e.addr, e.wdata});
                check("addr_ok", {inst_if.addr_ok, data_if.addr_ok}, {e.iaok, e.daok});
                check("busy", busy, e.busy);
                $display("cycle t=%0t mem_req=%0b addr=%h iaok=%0b daok=%0b busy=%0b",
                         $time, mem_if.req, mem_if.addr, inst_if.addr_ok, data_if.addr_ok, busy);
            end
            if (mem_if.data_ok || inst_if.data_ok || data_if.data_ok) begin
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL data_ok: got inst=%0b data=%0b expected no response",
                             inst_if.data_ok, data_if.data_ok);
                end else begin
                    r = rsp_q.pop_front();
                    check("data_ok", {inst_if.data_ok, data_if.data_ok}, {r.iok, r.dok});
                    check("rdata", {inst_if.rdata, data_if.rdata}, {r.rdata, r.rdata});
                end
            end
        end
    end

    task automatic model_reset();
        mdl_q.delete();
        cyc_q.delete();
        rsp_q.delete();
        stall_v   = 1'b0;
        stall_own = 1'b0;
        inst_pend = 1'b0;
        data_pend = 1'b0;
    endtask

    task automatic zero_inputs();
        inst_if.req     = 1'b0;
        inst_if.wr      = 1'b0;
        inst_if.size    = 2'd0;
        inst_if.wstrb   = 4'd0;
        inst_if.addr    = 32'd0;
        inst_if.wdata   = 32'd0;
        data_if.req     = 1'b0;
        data_if.wr      = 1'b0;
        data_if.size    = 2'd0;
        data_if.wstrb   = 4'd0;
        data_if.addr    = 32'd0;
        data_if.wdata   = 32'd0;
        mem_if.addr_ok  = 1'b0;
        mem_if.data_ok  = 1'b0;
        mem_if.rdata    = 32'd0;
        inst_cancel     = 1'b0;
    endtask

    task automatic drive_cycle(input int p_req, input int p_dok);
        bit   gv, gd, mreq, acc;
        int   size0;
        cyc_t c;
        rsp_t r;
        ent_t h;
        @(posedge clk);
        #1;
        if (!inst_pend && $urandom_range(99) < p_req) begin
            inst_pend    = 1'b1;
            inst_if.addr = $urandom & 32'hFFFF_FFFC;
            inst_if.size = 2'd2;
        end
        if (!data_pend && $urandom_range(99) < p_req) begin
            data_pend     = 1'b1;
            data_if.wr    = 1'($urandom_range(1));
            data_if.size  = 2'($urandom_range(2));
            data_if.wstrb = 4'($urandom_range(15));
            data_if.addr  = $urandom;
            data_if.wdata = $urandom;
        end
        inst_if.req    = inst_pend;
        data_if.req    = data_pend;
        mem_if.addr_ok = ($urandom_range(99) < 60);
        mem_if.rdata   = $urandom;
        inst_cancel    = ($urandom_range(99) < 8);
        size0          = mdl_q.size();
        mem_if.data_ok = (size0 != 0) ? ($urandom_range(99) < p_dok) : ($urandom_range(99) < 3);

        // Who owns the downstream this cycle.
        gv = 1'b0;
        gd = 1'b0;
        if (stall_v) begin
            gv = 1'b1;
            gd = stall_own;
        end else if (size0 < DEPTH) begin
            if (data_pend) begin
                gv = 1'b1;
                gd = 1'b1;
            end else if (inst_pend) begin
                gv = 1'b1;
            end
        end
        mreq = gv && (gd ? data_pend : inst_pend);
        acc  = mreq && mem_if.addr_ok;

        c.mreq  = mreq;
        c.wr    = gv && gd && data_if.wr;
        c.size  = !gv ? 2'd0 : (gd ? data_if.size : inst_if.size);
        c.wstrb = (gv && gd) ? data_if.wstrb : 4'd0;
        c.addr  = !gv ? 32'd0 : (gd ? data_if.addr : inst_if.addr);
        c.wdata = (gv && gd) ? data_if.wdata : 32'd0;
        c.iaok  = acc && !gd;
        c.daok  = acc && gd;
        c.busy  = (size0 != 0);
        cyc_q.push_back(c);

        if (mem_if.data_ok) begin
            r.rdata = mem_if.rdata;
            r.iok   = 1'b0;
            r.dok   = 1'b0;
            if (size0 != 0) begin
                h     = mdl_q.pop_front();
                r.dok = h.own;
                r.iok = !h.own && !h.drop && !inst_cancel;
            end
            rsp_q.push_back(r);
        end
        if (inst_cancel) begin
            foreach (mdl_q[i]) begin
                if (!mdl_q[i].own) mdl_q[i].drop = 1'b1;
            end
        end
        if (acc) begin
            h.own  = gd;
            h.drop = !gd && inst_cancel;
            mdl_q.push_back(h);
        end
        if (mreq && !mem_if.addr_ok) begin
            stall_v   = 1'b1;
            stall_own = gd;
        end else if (acc) begin
            stall_v = 1'b0;
        end
        if (c.iaok) inst_pend = 1'b0;
        if (c.daok) data_pend = 1'b0;
    endtask

    task automatic run_phase(input int ncyc, input int p_req, input int p_dok);
        for (int i = 0; i < ncyc; i++) drive_cycle(p_req, p_dok);
    endtask

    task automatic stop_monitor();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    initial begin
        zero_inputs();
        model_reset();
        resetn = 1'b0;
        #3;
        check("reset_outputs",
              {mem_if.req, mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata,
               inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok, busy},
              128'd0);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        run_phase(400, 70, 10);
        run_phase(1200, 50, 55);
        run_phase(30, 70, 0);
        stop_monitor();

        // Asynchronous reset with requests outstanding.
        zero_inputs();
        check("busy_before_reset", busy, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs",
              {mem_if.req, mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata,
               inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok,
               inst_if.rdata, busy},
              128'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hDEAD_BEEF;
        #1;
        check("stray_beat_data_ok", {inst_if.data_ok, data_if.data_ok}, 2'b00);
        @(posedge clk);
        #1;
        mem_if.data_ok = 1'b0;
        check("stray_beat_busy", busy, 1'b0);

        model_reset();
        mon_en = 1'b1;
        run_phase(300, 50, 45);
        stop_monitor();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
